// File: rtl/wb_trace_buffer_if.sv
// Bus bundle for wb_trace_buffer: CPU write-event inputs plus the record output stream.
// master = trace producer/consumer side, slave = the trace buffer itself.
interface wb_trace_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          grf_we;
  logic [31:0]   grf_pc;
  logic [4:0]    grf_addr;
  logic [31:0]   grf_wdata;
  logic          dm_we;
  logic [31:0]   dm_pc;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic          out_valid;
  logic          out_ready;
  logic          out_type;
  logic [31:0]   out_pc;
  logic [31:0]   out_addr;
  logic [31:0]   out_data;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_cnt;

  modport master (
    output grf_we, grf_pc, grf_addr, grf_wdata,
    output dm_we, dm_pc, dm_addr, dm_wdata,
    output out_ready,
    input  out_valid, out_type, out_pc, out_addr, out_data,
    input  count, overflow, drop_cnt
  );

  modport slave (
    input  grf_we, grf_pc, grf_addr, grf_wdata,
    input  dm_we, dm_pc, dm_addr, dm_wdata,
    input  out_ready,
    output out_valid, out_type, out_pc, out_addr, out_data,
    output count, overflow, drop_cnt
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Trace FIFO capturing CPU register-file and data-memory writes, up to two per cycle.
// Define WB_TRACE_FILTER_ZERO_EN to silently discard GRF writes to register 0.
module wb_trace_buffer #(
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               reset,
  wb_trace_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 97;

  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic          out_valid;
  logic          deq;
  logic          grf_ev;
  logic          grf_acc;
  logic          dm_acc;
  logic [1:0]    n_drop;
  logic [CW-1:0] occ_after_deq;
  logic [CW-1:0] free_slots;
  logic [AW-1:0] dm_idx;
  logic [16:0]   drop_sum;
  logic [RW-1:0] head_rec;

  assign out_valid = (count_q != '0);
  assign deq       = out_valid & bus.out_ready;

`ifdef WB_TRACE_FILTER_ZERO_EN
  assign grf_ev = bus.grf_we & (bus.grf_addr != 5'd0);
`else
  assign grf_ev = bus.grf_we;
`endif

  // Space is judged after this edge's dequeue; GRF has priority for the last slot.
  always_comb begin
    occ_after_deq = count_q - CW'(deq);
    free_slots    = CW'(DEPTH) - occ_after_deq;
    grf_acc       = grf_ev & (free_slots >= CW'(1));
    dm_acc        = bus.dm_we & (free_slots >= (grf_acc ? CW'(2) : CW'(1)));
    n_drop        = 2'(grf_ev & ~grf_acc) + 2'(bus.dm_we & ~dm_acc);
    dm_idx        = wr_ptr_q + AW'(grf_acc);
  end

  always_comb begin
    mem_d = mem_q;
    if (grf_acc) begin
      mem_d[wr_ptr_q] = {1'b0, bus.grf_pc, {27'd0, bus.grf_addr}, bus.grf_wdata};
    end
    if (dm_acc) begin
      mem_d[dm_idx] = {1'b1, bus.dm_pc, bus.dm_addr, bus.dm_wdata};
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q + AW'(deq);
    wr_ptr_d   = wr_ptr_q + AW'(grf_acc) + AW'(dm_acc);
    count_d    = count_q - CW'(deq) + CW'(grf_acc) + CW'(dm_acc);
    overflow_d = overflow_q | (n_drop != 2'd0);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Record storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head_rec = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  assign bus.out_valid = out_valid;
  assign bus.out_type  = head_rec[96];
  assign bus.out_pc    = head_rec[95:64];
  assign bus.out_addr  = head_rec[63:32];
  assign bus.out_data  = head_rec[31:0];
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: expected records queued at stimulus time,
// popped and compared by an independent monitor on every output handshake.
module tb_wb_trace_buffer;
  localparam int DEPTH = 8;

  typedef struct {
    logic        typ;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_fail;
  rec_t exp_q[$];

  wb_trace_buffer_if #(.DEPTH(DEPTH)) bus ();

  wb_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d, input bit push);
    rec_t r;
    bus.grf_we    = 1'b1;
    bus.grf_pc    = pc;
    bus.grf_addr  = a;
    bus.grf_wdata = d;
    if (push) begin
      r.typ = 1'b0; r.pc = pc; r.addr = {27'd0, a}; r.data = d;
      exp_q.push_back(r);
    end
  endtask

  task automatic set_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d, input bit push);
    rec_t r;
    bus.dm_we    = 1'b1;
    bus.dm_pc    = pc;
    bus.dm_addr  = a;
    bus.dm_wdata = d;
    if (push) begin
      r.typ = 1'b1; r.pc = pc; r.addr = a; r.data = d;
      exp_q.push_back(r);
    end
  endtask

  task automatic clr_ev();
    bus.grf_we = 1'b0;
    bus.dm_we  = 1'b0;
  endtask

  // Monitor: a record leaves at the next edge whenever valid&ready are seen here.
  always @(negedge clk) begin
    rec_t e;
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_record_pc", bus.out_pc, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        chk("rec_type", 32'(bus.out_type), 32'(e.typ));
        chk("rec_pc",   bus.out_pc,   e.pc);
        chk("rec_addr", bus.out_addr, e.addr);
        chk("rec_data", bus.out_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.out_ready = 1'b0;
    bus.grf_pc = '0; bus.grf_addr = '0; bus.grf_wdata = '0;
    bus.dm_pc = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    clr_ev();
    tick();
    tick();
    chk("rst_valid",    32'(bus.out_valid), 32'd0);
    chk("rst_count",    32'(bus.count), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    chk("rst_out_pc",   bus.out_pc, 32'd0);
    reset = 1'b1;

    // Single event, consumer ready
    bus.out_ready = 1'b1;
    set_grf(32'h3000, 5'd5, 32'h1234, 1'b1);
    tick();
    clr_ev();
    chk("s1_valid", 32'(bus.out_valid), 32'd1);
    chk("s1_type",  32'(bus.out_type), 32'd0);
    chk("s1_addr",  bus.out_addr, 32'd5);
    chk("s1_data",  bus.out_data, 32'h1234);
    tick();
    chk("s1_count_after", 32'(bus.count), 32'd0);
    chk("s1_idle_data",   bus.out_data, 32'd0);

    // Simultaneous GRF + DM, consumer stalled
    bus.out_ready = 1'b0;
    set_grf(32'h3004, 5'd8, 32'd7, 1'b1);
    set_dm(32'h3008, 32'h10, 32'd9, 1'b1);
    tick();
    clr_ev();
    chk("s2_count", 32'(bus.count), 32'd2);
    chk("s2_head_type", 32'(bus.out_type), 32'd0);
    tick();
    chk("s2_stable_pc", bus.out_pc, 32'h3004);
    bus.out_ready = 1'b1;
    tick();
    chk("s2_count1", 32'(bus.count), 32'd1);
    chk("s2_next_type", 32'(bus.out_type), 32'd1);
    tick();
    chk("s2_count0", 32'(bus.count), 32'd0);

    // Fill to 7, then a pair: DM dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_grf(32'h4000 + 32'(4 * i), 5'(i + 1), 32'h100 + 32'(i), 1'b1);
      tick();
    end
    clr_ev();
    chk("s3_count7", 32'(bus.count), 32'd7);
    set_grf(32'h5000, 5'd3, 32'hAA, 1'b1);
    set_dm(32'h5004, 32'h20, 32'hBB, 1'b0);
    tick();
    clr_ev();
    chk("s3_count8", 32'(bus.count), 32'd8);
    chk("s3_overflow", 32'(bus.overflow), 32'd1);
    chk("s3_drop1", 32'(bus.drop_cnt), 32'd1);
    set_grf(32'h5008, 5'd4, 32'hCC, 1'b0);
    set_dm(32'h500C, 32'h24, 32'hDD, 1'b0);
    tick();
    clr_ev();
    chk("s3_full_count", 32'(bus.count), 32'd8);
    chk("s3_drop3", 32'(bus.drop_cnt), 32'd3);

    // Full with dequeue accepts one event
    bus.out_ready = 1'b1;
    set_dm(32'h6000, 32'h40, 32'hCC, 1'b1);
    tick();
    clr_ev();
    chk("s4_count8", 32'(bus.count), 32'd8);
    chk("s4_no_drop", 32'(bus.drop_cnt), 32'd3);
    for (int i = 0; i < 20; i++) begin
      set_grf(32'h7000 + 32'(4 * i), 5'((i % 31) + 1), 32'(i) * 32'h1111_1111, 1'b1);
      tick();
    end
    clr_ev();
    chk("s4_wrap_count", 32'(bus.count), 32'd8);
    for (int i = 0; i < 8; i++) tick();
    chk("s4_drained", 32'(bus.count), 32'd0);
    chk("s4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while a handshake is offered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_grf(32'h9000 + 32'(4 * i), 5'd9, 32'(i), 1'b1);
      tick();
    end
    clr_ev();
    chk("s5_count3", 32'(bus.count), 32'd3);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    set_grf(32'h9100, 5'd2, 32'h77, 1'b0);
    tick();
    exp_q.delete();
    clr_ev();
    reset = 1'b1;
    bus.out_ready = 1'b0;
    chk("s5_valid", 32'(bus.out_valid), 32'd0);
    chk("s5_count", 32'(bus.count), 32'd0);
    chk("s5_overflow", 32'(bus.overflow), 32'd0);
    chk("s5_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    chk("s5_out_data", bus.out_data, 32'd0);

    // Ready while empty has no effect
    bus.out_ready = 1'b1;
    tick();
    chk("s6_empty_ready", 32'(bus.count), 32'd0);
    bus.out_ready = 1'b0;

    // Register-zero write
`ifdef WB_TRACE_FILTER_ZERO_EN
    set_grf(32'h8000, 5'd0, 32'h55, 1'b0);
    tick();
    clr_ev();
    chk("s7_zero_count", 32'(bus.count), 32'd0);
    chk("s7_zero_overflow", 32'(bus.overflow), 32'd0);
    chk("s7_zero_drop", 32'(bus.drop_cnt), 32'd0);
`else
    set_grf(32'h8000, 5'd0, 32'h55, 1'b1);
    tick();
    clr_ev();
    chk("s7_zero_count", 32'(bus.count), 32'd1);
    chk("s7_zero_addr", bus.out_addr, 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("s7_zero_drained", 32'(bus.count), 32'd0);
`endif
    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameter: DEPTH, default 8, FIFO entries (power of two, 4..32).
REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous active-low reset; reset==0 at a rising edge resets the block.
- grf_we  in  1  CPU register-file write event this cycle.
- grf_pc  in  32  PC of the writing instruction.
- grf_addr  in  5  destination register.
- grf_wdata  in  32  value written.
- dm_we  in  1  CPU data-memory write event this cycle.
- dm_pc  in  32  PC of the storing instruction.
- dm_addr  in  32  byte address, word aligned.
- dm_wdata  in  32  value stored.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_type  out  1  0 = GRF record, 1 = DM record.
- out_pc  out  32  record PC.
- out_addr  out  32  GRF record: register number zero-extended; DM record: dm_addr.
- out_data  out  32  record data.
- count  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when any event has been dropped.
- drop_cnt  out  16  number of dropped events, saturating.

Function
REQ-003 Each rising edge with grf_we=1 SHALL produce one GRF record; each edge with dm_we=1 SHALL produce one DM record.
REQ-004 When grf_we and dm_we are both 1 on the same edge, the GRF record SHALL be enqueued ahead of the DM record, because the writeback stage holds the older instruction.
REQ-005 Records SHALL enqueue with 1-cycle latency: an event sampled at edge N is visible at the head no earlier than after edge N.
REQ-006 An empty FIFO SHALL present the first record on out_valid the cycle after the event.
REQ-007 A record SHALL dequeue at an edge where out_valid=1 and out_ready=1.
REQ-008 out_* fields SHALL stay stable while out_valid=1 and out_ready=0.
REQ-009 Free slots SHALL be computed after the same-edge dequeue, so a full FIFO with a dequeue accepts one event.
REQ-010 The block SHALL accept up to two events per edge.
REQ-011 When only one slot is free and two events arrive, the GRF record SHALL be kept and the DM record dropped.
REQ-012 When no slot is free, all arriving events SHALL be dropped.
REQ-013 Each dropped event SHALL set overflow and increment drop_cnt by 1, saturating at 16'hFFFF.
REQ-014 The read and write pointers SHALL wrap modulo DEPTH.
REQ-015 count SHALL equal the number of stored records, 0..DEPTH.
REQ-016 When out_valid=0, out_type, out_pc, out_addr and out_data SHALL be 0.
REQ-017 out_ready asserted while the FIFO is empty SHALL have no effect.

Reset
REQ-018 While reset==0 at a rising edge, both pointers SHALL return to 0 and count, out_valid, overflow and drop_cnt SHALL be 0, discarding stored records.
REQ-019 Events present on the reset edge SHALL be ignored, and a handshake in progress SHALL be abandoned without a dequeue.
REQ-020 The first edge with reset==1 SHALL operate normally.

Configuration
REQ-021 Macro WB_TRACE_FILTER_ZERO_EN, when defined: a GRF event with grf_addr==0 SHALL be discarded silently, with no record, no drop count and no overflow.
REQ-022 Macro WB_TRACE_FILTER_ZERO_EN, when not defined: GRF events to register 0 SHALL be recorded like any other GRF event.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single event: reset, then grf_we=1, pc=0x3000, addr=5, data=0x1234 with out_ready=1 -> next cycle out_valid=1, type=0, out_addr=5, out_data=0x1234; after the handshake count=0.
- Simultaneous events: grf (pc 0x3004, $8, 7) and dm (pc 0x3008, addr 0x10, 9) on one edge with out_ready=0 -> count=2; head=GRF, then DM after one handshake.
- Full with pair: DEPTH=8, 7 records stored, out_ready=0, then a GRF+DM pair -> count=8, DM dropped, overflow=1, drop_cnt=1.
- Full with dequeue: full FIFO, out_ready=1, one dm event -> count stays 8, no drop; wrap: 20 enqueue/dequeue cycles -> records emerge in order and match a reference queue.
- Reset mid-stream: 3 records stored and reset==0 for one edge while out_valid=1 -> out_valid=0, count=0, overflow=0, drop_cnt=0.
- Zero register: grf_addr=0 event -> no record and count=0 with WB_TRACE_FILTER_ZERO_EN defined; count=1 without it.
